mult_booth4_ctrl: RTL and testbench

- Sequenced radix-4 (modified Booth) signed multiplier core for the multdiv unit.
- Holds the combined product/multiplier shift register and the iteration counter.
- Each cycle it encodes 3 multiplier bits, adds 0/±A/±2A to the upper half, then arithmetic-right-shifts the register by 2.
- Produces a 32-bit result, an overflow exception and a one-cycle ready pulse; the multdiv top muxes it against the divider.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/mult_booth4_ctrl_step.sv | 57 +++++
 rtl/mult_booth4_ctrl.sv | 90 +++++++++
 tb/tb_mult_booth4_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants, state encoding and Booth digit codes for the radix-4 multiplier.
// The Booth code is the low three bits of the product/multiplier register.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  function automatic int iter_count(input int w);
    return w / 2;
  endfunction

  localparam int ITER = iter_count(MULT_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  localparam logic [2:0] BOOTH_Z0  = 3'b000;
  localparam logic [2:0] BOOTH_P1A = 3'b001;
  localparam logic [2:0] BOOTH_P1B = 3'b010;
  localparam logic [2:0] BOOTH_P2  = 3'b011;
  localparam logic [2:0] BOOTH_M2  = 3'b100;
  localparam logic [2:0] BOOTH_M1A = 3'b101;
  localparam logic [2:0] BOOTH_M1B = 3'b110;
  localparam logic [2:0] BOOTH_Z1  = 3'b111;

endpackage

// File: rtl/mult_booth4_ctrl_step.sv
// One radix-4 Booth iteration: encode P[2:0], add 0/+-A/+-2A into the upper field,
// then arithmetic shift the whole register right by two.
module booth4_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [2*WIDTH+2:0] p,
  input  logic [WIDTH-1:0]   a,
  output logic [2*WIDTH+2:0] p_next
);

  localparam int HW = WIDTH + 2;

  logic [HW-1:0]      hi;
  logic [HW-1:0]      a_ext;
  logic [HW-1:0]      operand;
  logic               cin;
  logic [HW-1:0]      sum;
  logic [2*WIDTH+2:0] updated;

  assign hi    = p[2*WIDTH+2:WIDTH+1];
  assign a_ext = {{2{a[WIDTH-1]}}, a};

  // Subtraction uses the inverted operand; its +1 rides in as the carry-in.
  always_comb begin
    operand = '0;
    cin     = 1'b0;
    case (p[2:0])
      BOOTH_P1A, BOOTH_P1B: begin
        operand = a_ext;
        cin     = 1'b0;
      end
      BOOTH_P2: begin
        operand = {a_ext[HW-2:0], 1'b0};
        cin     = 1'b0;
      end
      BOOTH_M2: begin
        operand = ~{a_ext[HW-2:0], 1'b0};
        cin     = 1'b1;
      end
      BOOTH_M1A, BOOTH_M1B: begin
        operand = ~a_ext;
        cin     = 1'b1;
      end
      default: begin
        operand = '0;
        cin     = 1'b0;
      end
    endcase
  end

  assign sum     = hi + operand + {{(HW-1){1'b0}}, cin};
  assign updated = {sum, p[WIDTH:0]};
  assign p_next  = {{2{sum[HW-1]}}, updated[2*WIDTH+2:2]};

endmodule

// File: rtl/mult_booth4_ctrl.sv
// Sequenced radix-4 Booth signed multiplier: holds P, the latched multiplicand,
// the iteration counter and the registered result/exception/ready outputs.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT
// RUN   | one Booth iteration per clock, WIDTH/2 in total
// DONE  | result registered, data_resultRDY high for this one cycle
module mult_booth4_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int PW     = 2*WIDTH + 3;
  localparam int ITER_N = iter_count(WIDTH);
  localparam int CW     = (ITER_N > 1) ? $clog2(ITER_N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER_N - 1);

  mult_state_e      state;
  logic [PW-1:0]    p;
  logic [PW-1:0]    p_next;
  logic [WIDTH-1:0] a_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   top_bits;
  logic             overflow;

  booth4_step #(.WIDTH(WIDTH)) u_step (
    .p      (p),
    .a      (a_reg),
    .p_next (p_next)
  );

  // Product bits 2W-1..W-1 must all match the result sign for it to fit.
  assign top_bits = p_next[2*WIDTH:WIDTH];
  assign overflow = !((&top_bits) || !(|top_bits));

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      p              <= '0;
      a_reg          <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_MULT) begin
      state          <= ST_RUN;
      p              <= {{(WIDTH+2){1'b0}}, data_operandB, 1'b0};
      a_reg          <= data_operandA;
      cnt            <= '0;
      busy           <= 1'b1;
      data_resultRDY <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state          <= ST_DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= p_next[WIDTH:1];
            data_exception <= overflow;
          end
        end
        ST_DONE: begin
          state          <= ST_IDLE;
          data_resultRDY <= 1'b0;
        end
        default: begin
          state          <= ST_IDLE;
          busy           <= 1'b0;
          data_resultRDY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth4_ctrl.sv
// Bench for mult_booth4_ctrl: product/latency model checked every cycle, plus
// directed vectors with hand-computed results.
module tb_mult_booth4_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int total = 0;
  int bad = 0;
  int rdy_seen = 0;

  mult_booth4_ctrl #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint sx32(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  // Model: full signed product, result appears 16 edges after the start edge.
  logic        model_on = 1'b0;
  int          m_left = 0;
  longint      m_prod = 0;
  logic        m_busy = 1'b0;
  logic        m_rdy = 1'b0;
  logic [31:0] m_res = '0;
  logic        m_exc = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_left = 0;
      m_busy = 1'b0;
      m_rdy  = 1'b0;
      m_res  = '0;
      m_exc  = 1'b0;
      model_on = 1'b1;
    end else if (ctrl_MULT) begin
      m_prod = sx32(data_operandA) * sx32(data_operandB);
      m_left = 16;
      m_busy = 1'b1;
      m_rdy  = 1'b0;
    end else begin
      m_rdy = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_rdy  = 1'b1;
          m_res  = m_prod[31:0];
          m_exc  = (m_prod != sx32(m_prod[31:0]));
        end
      end
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("rdy", {31'b0, data_resultRDY}, {31'b0, m_rdy});
      check("result", data_result, m_res);
      check("exception", {31'b0, data_exception}, {31'b0, m_exc});
      if (data_resultRDY) rdy_seen++;
    end
  end

  task automatic kick(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(input string name, input logic [31:0] exp_res, input logic exp_exc);
    int k;
    int nb;
    k  = 0;
    nb = busy ? 1 : 0;
    while (!data_resultRDY && k < 40) begin
      @(negedge clock);
      k++;
      if (busy) nb++;
    end
    check({name, "_latency"}, k, 16);
    check({name, "_busy_cycles"}, nb, 16);
    check({name, "_result"}, data_result, exp_res);
    check({name, "_exc"}, {31'b0, data_exception}, {31'b0, exp_exc});
  endtask

  initial begin
    int s0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
    check("reset_result", data_result, 32'd0);
    check("reset_exc", {31'b0, data_exception}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    kick(32'd3, 32'd5);
    wait_rdy("3x5", 32'd15, 1'b0);
    repeat (2) @(negedge clock);

    kick(32'hFFFFFFF9, 32'd6);
    wait_rdy("m7x6", 32'hFFFFFFD6, 1'b0);
    kick(32'd6, 32'hFFFFFFF9);
    wait_rdy("6xm7", 32'hFFFFFFD6, 1'b0);
    repeat (2) @(negedge clock);

    kick(32'h7FFFFFFF, 32'd2);
    wait_rdy("ovf_max_x2", 32'hFFFFFFFE, 1'b1);
    repeat (2) @(negedge clock);
    kick(32'h80000000, 32'hFFFFFFFF);
    wait_rdy("ovf_min_xm1", 32'h80000000, 1'b1);
    repeat (2) @(negedge clock);
    kick(32'h00010000, 32'h00010000);
    wait_rdy("ovf_2p32", 32'd0, 1'b1);
    repeat (2) @(negedge clock);

    kick(32'd0, 32'hFFFFFFFB);
    wait_rdy("zero_a", 32'd0, 1'b0);
    repeat (2) @(negedge clock);

    // Abort: restart mid-run, only the second op may report.
    kick(32'd3, 32'd5);
    repeat (7) @(negedge clock);
    s0 = rdy_seen;
    kick(32'hFFFFFFFC, 32'hFFFFFFFC);
    wait_rdy("abort", 32'd16, 1'b0);
    repeat (3) @(negedge clock);
    check("abort_rdy_count", rdy_seen - s0, 1);

    // Reset mid-run, with a start on the same edge that must be ignored.
    kick(32'd3, 32'd5);
    repeat (9) @(negedge clock);
    s0 = rdy_seen;
    reset         = 1'b1;
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd7;
    data_operandB = 32'd7;
    @(negedge clock);
    reset     = 1'b0;
    ctrl_MULT = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rdy", {31'b0, data_resultRDY}, 32'd0);
    check("rst_result", data_result, 32'd0);
    check("rst_exc", {31'b0, data_exception}, 32'd0);
    repeat (25) @(negedge clock);
    check("rst_no_rdy", rdy_seen - s0, 0);
    check("rst_idle_busy", {31'b0, busy}, 32'd0);

    // Back-to-back: new start on the RDY cycle.
    kick(32'd1000, 32'hFFFFFFFD);
    wait_rdy("b2b_first", 32'hFFFFF448, 1'b0);
    kick(32'd2, 32'hFFFFFFFF);
    wait_rdy("b2b_second", 32'hFFFFFFFE, 1'b0);
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
